// File: rtl/controle_elevador_andar.sv
// controle_elevador_andar
// Floor-motion controller for the SmartCargo lift. It filters the 2-bit
// floor code from the floor interpreter into a confirmed floor. It accepts
// one target-floor request at a time, drives the up/down motor enables,
// stops on confirmed arrival and then holds the door open for a fixed time.
//
// Optional feature: define CONTROLE_ANDAR_TIMEOUT_EN to add a stall watchdog
// and the ERRO state. The TIMEOUT_CYCLES parameter exists only in that build.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous, active-low reset
//   andar_atual      in   [1:0] floor code sample
//   andar_valido     in   one-cycle pulse, andar_atual is a new sample
//   pedido_andar     in   [1:0] requested target floor
//   pedido_valido    in   request valid
//   pedido_pronto    out  request ready (OCIOSO only)
//   motor_sobe       out  motor up enable
//   motor_desce      out  motor down enable
//   porta_aberta     out  door open
//   chegou           out  one-cycle arrival pulse (first PORTA cycle)
//   andar_confirmado out  [1:0] filtered current floor
//   erro             out  stall error flag
//   estado_db        out  [2:0] FSM state code
//
// state    | meaning
// OCIOSO   | idle, ready for a request
// AVALIA   | one cycle, compares target with confirmed floor
// SUBINDO  | moving up
// DESCENDO | moving down
// PORTA    | door open for DOOR_CYCLES cycles
// ERRO     | watchdog stall, exits only by reset (watchdog build only)

module controle_elevador_andar #(
  parameter int STABLE_COUNT = 3,
  parameter int DOOR_CYCLES  = 50000000
`ifdef CONTROLE_ANDAR_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 500000000
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] andar_atual,
  input  logic       andar_valido,
  input  logic [1:0] pedido_andar,
  input  logic       pedido_valido,
  output logic       pedido_pronto,
  output logic       motor_sobe,
  output logic       motor_desce,
  output logic       porta_aberta,
  output logic       chegou,
  output logic [1:0] andar_confirmado,
  output logic       erro,
  output logic [2:0] estado_db
);

  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] AVALIA   = 3'd1;
  localparam logic [2:0] SUBINDO  = 3'd2;
  localparam logic [2:0] DESCENDO = 3'd3;
  localparam logic [2:0] PORTA    = 3'd4;
`ifdef CONTROLE_ANDAR_TIMEOUT_EN
  localparam logic [2:0] ERRO     = 3'd5;
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);
`endif

  localparam logic [3:0]  STABLE_Q  = 4'(STABLE_COUNT);
  localparam logic [31:0] DOOR_LOAD = 32'(DOOR_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  alvo_q, alvo_d;
  logic [1:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  conf_q, conf_d;
  logic [31:0] door_q, door_d;
  logic        chegou_q, chegou_d;
`ifdef CONTROLE_ANDAR_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
`endif

  // Floor filter: runs in every state, independent of the FSM.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    conf_d = conf_q;
    if (andar_valido) begin
      if (andar_atual == cand_q) begin
        cnt_d = (cnt_q >= STABLE_Q) ? STABLE_Q : cnt_q + 4'd1;
      end else begin
        cand_d = andar_atual;
        cnt_d  = 4'd1;
      end
      // Uses the next-state candidate so STABLE_COUNT=1 confirms a new floor at once.
      if (cnt_d == STABLE_Q) conf_d = cand_d;
    end
  end

  // FSM reacts to the registered confirmed floor, so a confirmation at edge m
  // moves the state at edge m+1.
  always_comb begin
    state_d = state_q;
    alvo_d  = alvo_q;
    door_d  = door_q;
    case (state_q)
      OCIOSO: begin
        if (pedido_valido) begin
          alvo_d  = pedido_andar;
          state_d = AVALIA;
        end
      end
      AVALIA: begin
        if (alvo_q == conf_q)     state_d = PORTA;
        else if (alvo_q > conf_q) state_d = SUBINDO;
        else                      state_d = DESCENDO;
      end
      SUBINDO: begin
        if (conf_q == alvo_q)     state_d = PORTA;
        else if (conf_q > alvo_q) state_d = DESCENDO;
`ifdef CONTROLE_ANDAR_TIMEOUT_EN
        else if (wd_q >= WD_LIMIT) state_d = ERRO;
`endif
      end
      DESCENDO: begin
        if (conf_q == alvo_q)     state_d = PORTA;
        else if (conf_q < alvo_q) state_d = SUBINDO;
`ifdef CONTROLE_ANDAR_TIMEOUT_EN
        else if (wd_q >= WD_LIMIT) state_d = ERRO;
`endif
      end
      PORTA: begin
        if (door_q == 32'd0) state_d = OCIOSO;
        else                 door_d  = door_q - 32'd1;
      end
`ifdef CONTROLE_ANDAR_TIMEOUT_EN
      ERRO: state_d = ERRO;
`endif
      default: state_d = OCIOSO;
    endcase
    // Door timer loads on entry; PORTA lasts exactly DOOR_CYCLES cycles.
    if (state_d == PORTA && state_q != PORTA) door_d = DOOR_LOAD;
  end

  assign chegou_d = (state_d == PORTA) && (state_q != PORTA);

`ifdef CONTROLE_ANDAR_TIMEOUT_EN
  // Watchdog restarts on every entry to a motion state (including a
  // reversal after overshoot) and whenever the confirmed floor moves.
  always_comb begin
    wd_d = wd_q;
    if (((state_d == SUBINDO || state_d == DESCENDO) && state_d != state_q) ||
        (conf_d != conf_q))
      wd_d = 32'd0;
    else if (state_q == SUBINDO || state_q == DESCENDO)
      wd_d = wd_q + 32'd1;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= OCIOSO;
      alvo_q   <= 2'd0;
      cand_q   <= 2'd0;
      cnt_q    <= 4'd0;
      conf_q   <= 2'd0;
      door_q   <= 32'd0;
      chegou_q <= 1'b0;
`ifdef CONTROLE_ANDAR_TIMEOUT_EN
      wd_q     <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      alvo_q   <= alvo_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      conf_q   <= conf_d;
      door_q   <= door_d;
      chegou_q <= chegou_d;
`ifdef CONTROLE_ANDAR_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign pedido_pronto    = (state_q == OCIOSO);
  assign motor_sobe       = (state_q == SUBINDO);
  assign motor_desce      = (state_q == DESCENDO);
  assign porta_aberta     = (state_q == PORTA);
  assign chegou           = chegou_q;
  assign andar_confirmado = conf_q;
  assign estado_db        = state_q;
`ifdef CONTROLE_ANDAR_TIMEOUT_EN
  assign erro = (state_q == ERRO);
`else
  assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_controle_elevador_andar.sv
module tb_controle_elevador_andar;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] andar_atual;
  logic       andar_valido;
  logic [1:0] pedido_andar;
  logic       pedido_valido;
  logic       pedido_pronto;
  logic       motor_sobe;
  logic       motor_desce;
  logic       porta_aberta;
  logic       chegou;
  logic [1:0] andar_confirmado;
  logic       erro;
  logic [2:0] estado_db;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  controle_elevador_andar #(
    .STABLE_COUNT(3),
    .DOOR_CYCLES(8)
`ifdef CONTROLE_ANDAR_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .andar_atual(andar_atual),
    .andar_valido(andar_valido),
    .pedido_andar(pedido_andar),
    .pedido_valido(pedido_valido),
    .pedido_pronto(pedido_pronto),
    .motor_sobe(motor_sobe),
    .motor_desce(motor_desce),
    .porta_aberta(porta_aberta),
    .chegou(chegou),
    .andar_confirmado(andar_confirmado),
    .erro(erro),
    .estado_db(estado_db)
  );

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [1:0] v);
    andar_atual  = v;
    andar_valido = 1'b1;
    step();
    andar_valido = 1'b0;
  endtask

  task automatic request(input logic [1:0] v);
    pedido_andar  = v;
    pedido_valido = 1'b1;
    step();
    pedido_valido = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    andar_atual = 2'd0; andar_valido = 1'b0;
    pedido_andar = 2'd0; pedido_valido = 1'b0;
    @(negedge clock);
    step();
    step();
    reset = 1'b1;
    chk("rst_estado", estado_db, 0);
    chk("rst_pronto", pedido_pronto, 1);
    chk("rst_sobe", motor_sobe, 0);
    chk("rst_desce", motor_desce, 0);
    chk("rst_porta", porta_aberta, 0);
    chk("rst_chegou", chegou, 0);
    chk("rst_conf", andar_confirmado, 0);
    chk("rst_erro", erro, 0);

    // Filter: 2,2,1,1,1
    sample(2'd2); chk("flt_a", andar_confirmado, 0);
    sample(2'd2); chk("flt_b", andar_confirmado, 0);
    sample(2'd1); chk("flt_c", andar_confirmado, 0);
    sample(2'd1); chk("flt_d", andar_confirmado, 0);
    step();       chk("flt_gap", andar_confirmado, 0);
    sample(2'd1); chk("flt_e", andar_confirmado, 1);

    // Back to floor 0
    sample(2'd0); sample(2'd0);
    chk("flt_f", andar_confirmado, 1);
    sample(2'd0); chk("flt_g", andar_confirmado, 0);

    // Upward trip 0 -> 2
    request(2'd2);
    chk("up_avalia", estado_db, 1);
    chk("up_pronto", pedido_pronto, 0);
    chk("up_sobe0", motor_sobe, 0);
    step();
    chk("up_estado", estado_db, 2);
    chk("up_sobe1", motor_sobe, 1);
    request(2'd3);
    chk("up_ignreq", estado_db, 2);
    sample(2'd2); chk("up_s1", motor_sobe, 1);
    sample(2'd2); chk("up_s2", motor_sobe, 1);
    sample(2'd2);
    chk("up_conf", andar_confirmado, 2);
    chk("up_s3", motor_sobe, 1);
    step();
    chk("up_arr_estado", estado_db, 4);
    chk("up_arr_sobe", motor_sobe, 0);
    chk("up_arr_porta", porta_aberta, 1);
    chk("up_arr_chegou", chegou, 1);
    step();
    chk("up_chegou_once", chegou, 0);
    chk("up_porta2", porta_aberta, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("up_porta_hold", porta_aberta, 1);
      chk("up_chegou_low", chegou, 0);
    end
    step();
    chk("up_porta_off", porta_aberta, 0);
    chk("up_pronto_back", pedido_pronto, 1);

    // Same-floor request (floor 2)
    request(2'd2);
    chk("same_avalia", estado_db, 1);
    step();
    chk("same_porta", porta_aberta, 1);
    chk("same_chegou", chegou, 1);
    chk("same_sobe", motor_sobe, 0);
    chk("same_desce", motor_desce, 0);
    for (int i = 0; i < 8; i++) step();
    chk("same_done", estado_db, 0);

    // Overshoot: floor 0, target 1, confirmed jumps to 2
    sample(2'd0); sample(2'd0); sample(2'd0);
    chk("os_conf0", andar_confirmado, 0);
    request(2'd1);
    step();
    chk("os_sobe", motor_sobe, 1);
    sample(2'd2); sample(2'd2); sample(2'd2);
    chk("os_conf2", andar_confirmado, 2);
    step();
    chk("os_desce", motor_desce, 1);
    chk("os_sobe_off", motor_sobe, 0);
    sample(2'd1); sample(2'd1);
    chk("os_desce_hold", motor_desce, 1);
    sample(2'd1);
    chk("os_conf1", andar_confirmado, 1);
    step();
    chk("os_arr_estado", estado_db, 4);
    chk("os_arr_desce", motor_desce, 0);
    chk("os_arr_chegou", chegou, 1);
    for (int i = 0; i < 8; i++) step();
    chk("os_done", pedido_pronto, 1);

    // Reset during descent
    request(2'd0);
    step();
    chk("rm_desce", motor_desce, 1);
    reset = 1'b0;
    step();
    chk("rm_estado", estado_db, 0);
    chk("rm_desce_off", motor_desce, 0);
    chk("rm_porta", porta_aberta, 0);
    chk("rm_pronto", pedido_pronto, 1);
    chk("rm_conf", andar_confirmado, 0);
    reset = 1'b1;
    step();
    chk("rm_lost", estado_db, 0);

    // Stall: moving with no floor samples
    request(2'd2);
    step();
    chk("st_sobe", motor_sobe, 1);
    for (int i = 0; i < 100; i++) step();
`ifdef CONTROLE_ANDAR_TIMEOUT_EN
    chk("st_erro", erro, 1);
    chk("st_estado", estado_db, 5);
    chk("st_sobe_off", motor_sobe, 0);
    chk("st_pronto", pedido_pronto, 0);
    request(2'd0);
    chk("st_stuck", estado_db, 5);
`else
    chk("st_erro", erro, 0);
    chk("st_sobe_on", motor_sobe, 1);
    chk("st_estado", estado_db, 2);
`endif
    reset = 1'b0;
    step();
    chk("st_reset", estado_db, 0);
    chk("st_erro_clr", erro, 0);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
